board_writer: RTL

- Owns the 3x3 tic-tac-toe board state and is the only block that writes the nine 2-bit cell fields read by the board-full and winner detectors.
- Accepts move requests over a valid/ready handshake, checks that each move is legal, and commits it for the current player.
- Alternates turns and freezes the board when the game ends, until a new-game request.
- Sits between the move source (keypad/FSM/computer player) and the combinational detectors.

---
 rtl/board_writer_pkg.sv | 23 ++
 rtl/board_cell.sv | 25 ++
 rtl/board_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/board_writer_pkg.sv
// Shared definitions for the tic-tac-toe board writer and the board detectors:
// cell codes, FSM state encoding and move limits.
package board_writer_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [3:0] POS_MIN   = 4'd1;
  localparam logic [3:0] POS_MAX   = 4'd9;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    WAIT = 2'b00,
    EVAL = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_cell.sv
// One 2-bit board cell: synchronous clear has priority over a write.
module board_cell
  import board_writer_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       we,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] q_r;

  // Cell storage register.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_r <= CELL_EMPTY;
    end else if (we) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/board_writer.sv
// Owns the 3x3 board: validates handshaked moves, commits them for the
// current player, alternates turns and freezes the board when the game ends.
module board_writer
  import board_writer_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_ok,
  output logic       move_illegal,
  input  logic       game_over,
  output logic       game_done,
  output logic [1:0] turn,
  output logic [3:0] move_count,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9
);

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] turn_r;
  logic [3:0] count_r;
  logic       ok_r;
  logic       illegal_r;

  logic [1:0] cell_q_s [9];
  logic [8:0] we_s;
  logic [1:0] target_s;
  logic       in_range_s;
  logic       legal_s;
  logic       hs_s;
  logic       clear_s;

  // new_game outranks a same-cycle handshake, so it blocks the commit here.
  assign hs_s    = move_valid && (state_r == WAIT) && !new_game;
  assign clear_s = reset || new_game;

  // Legality: position in range and the addressed cell currently empty.
  always_comb begin
    target_s   = CELL_EMPTY;
    in_range_s = (move_pos >= POS_MIN) && (move_pos <= POS_MAX);
    for (int i = 0; i < 9; i++) begin
      target_s = (move_pos == 4'(i + 1)) ? cell_q_s[i] : target_s;
    end
    legal_s = in_range_s && (target_s == CELL_EMPTY);
  end

  for (genvar g = 0; g < 9; g++) begin : g_cell
    assign we_s[g] = hs_s && legal_s && (move_pos == 4'(g + 1));

    board_cell u_cell (
      .clock (clock),
      .clear (clear_s),
      .we    (we_s[g]),
      .d     (turn_r),
      .q     (cell_q_s[g])
    );
  end

  // Next-state decision; new_game always returns to WAIT.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      WAIT: begin
        if (hs_s) begin
          next_state_s = EVAL;
        end else begin
          next_state_s = WAIT;
        end
      end
      EVAL: begin
        if (game_over || (count_r == MAX_MOVES)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE:    next_state_s = DONE;
      default: next_state_s = WAIT;
    endcase
    if (new_game) begin
      next_state_s = WAIT;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State register, turn, move counter and result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= WAIT;
      turn_r    <= FIRST_PLAYER;
      count_r   <= 4'd0;
      ok_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      ok_r      <= hs_s && legal_s;
      illegal_r <= hs_s && !legal_s;
      if (new_game) begin
        turn_r  <= FIRST_PLAYER;
        count_r <= 4'd0;
      end else if (hs_s && legal_s) begin
        turn_r <= other_player(turn_r);
        if (count_r != MAX_MOVES) begin
          count_r <= count_r + 4'd1;
        end
      end
    end
  end

  assign move_ready   = (state_r == WAIT);
  assign game_done    = (state_r == DONE);
  assign move_ok      = ok_r;
  assign move_illegal = illegal_r;
  assign turn         = turn_r;
  assign move_count   = count_r;

  assign pos1 = cell_q_s[0];
  assign pos2 = cell_q_s[1];
  assign pos3 = cell_q_s[2];
  assign pos4 = cell_q_s[3];
  assign pos5 = cell_q_s[4];
  assign pos6 = cell_q_s[5];
  assign pos7 = cell_q_s[6];
  assign pos8 = cell_q_s[7];
  assign pos9 = cell_q_s[8];

endmodule
